// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operator-entry front end.
package calc_pkg;

    typedef enum logic [2:0] {
        S_GET_A  = 3'd0,
        S_GET_B  = 3'd1,
        S_GET_OP = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_SHOW   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    localparam int KEY_ENTER  = 0;
    localparam int KEY_CANCEL = 1;

endpackage

// File: rtl/calc_entry_seq_if.sv
// Command/response handshake between the entry sequencer (master) and the calculator (slave).
interface calc_entry_seq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic       rsp_valid;
    logic [3:0] rsp_r;
    logic       rsp_ovf;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op,
        input  cmd_ready, rsp_valid, rsp_r, rsp_ovf
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op,
        output cmd_ready, rsp_valid, rsp_r, rsp_ovf
    );

endinterface

// File: rtl/key_debounce.sv
// Debouncer for one active-low pushbutton: 2-FF synchronizer, stability counter,
// and a one-cycle press pulse on an accepted released->pressed transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    // The counter only runs while the synchronized level disagrees with the accepted level,
    // so any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_entry_seq.sv
// Operator-entry sequencer: debounced keys step through A/B/opcode entry, issue one command,
// then capture and hold the result. Optional S_WAIT timeout enabled by CALC_TIMEOUT_EN.
module calc_entry_seq
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [2:0]       KEY,
    input  logic [3:0]       SW,
    calc_entry_seq_if.master bus,
    output logic [3:0]       disp_r,
    output logic             disp_ovf,
    output logic [2:0]       phase
);

    logic [2:0] key_press;
    logic       enter_p;
    logic       cancel_p;
    logic       cancel_ok;
    logic       unused_key2;

    state_t     state;
    logic       cmd_valid;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
            .clk   (CLOCK_50),
            .rst   (RESET),
            .key_n (KEY[k]),
            .press (key_press[k])
        );
    end

    assign enter_p     = key_press[KEY_ENTER];
    assign cancel_p    = key_press[KEY_CANCEL];
    assign unused_key2 = key_press[2];

    // Cancel is locked out while a command is outstanding so valid is never withdrawn
    // and a response is never orphaned.
    assign cancel_ok = cancel_p && (state != S_ISSUE) && (state != S_WAIT);

    assign phase         = state;
    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_a     = cmd_a;
    assign bus.cmd_b     = cmd_b;
    assign bus.cmd_op    = cmd_op;

`ifdef CALC_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= S_GET_A;
            cmd_valid <= 1'b0;
            cmd_a     <= '0;
            cmd_b     <= '0;
            cmd_op    <= '0;
            disp_r    <= '0;
            disp_ovf  <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else if (cancel_ok) begin
            state    <= S_GET_A;
            cmd_a    <= '0;
            cmd_b    <= '0;
            cmd_op   <= '0;
            disp_r   <= '0;
            disp_ovf <= 1'b0;
        end else begin
            unique case (state)
                S_GET_A: if (enter_p) begin
                    cmd_a <= SW;
                    state <= S_GET_B;
                end
                S_GET_B: if (enter_p) begin
                    cmd_b <= SW;
                    state <= S_GET_OP;
                end
                S_GET_OP: if (enter_p) begin
                    cmd_op    <= SW[2:0];
                    cmd_valid <= 1'b1;
                    state     <= S_ISSUE;
                end
                S_ISSUE: if (bus.cmd_ready) begin
                    cmd_valid <= 1'b0;
                    state     <= S_WAIT;
`ifdef CALC_TIMEOUT_EN
                    tmo_cnt   <= '0;
`endif
                end
                S_WAIT: begin
                    if (bus.rsp_valid) begin
                        disp_r   <= bus.rsp_r;
                        disp_ovf <= bus.rsp_ovf;
                        state    <= S_SHOW;
                    end
`ifdef CALC_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        disp_r   <= '0;
                        disp_ovf <= 1'b1;
                        state    <= S_SHOW;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                S_SHOW: if (enter_p) begin
                    state <= S_GET_A;
                end
                default: begin
                    state     <= S_GET_A;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_seq.sv
// Directed bench for calc_entry_seq: table-driven key entry plus hand-written handshake,
// response, cancel-lockout, timeout and reset sequences.
module tb_calc_entry_seq;

    localparam logic [2:0] P_GET_A  = 3'd0;
    localparam logic [2:0] P_GET_B  = 3'd1;
    localparam logic [2:0] P_GET_OP = 3'd2;
    localparam logic [2:0] P_ISSUE  = 3'd3;
    localparam logic [2:0] P_WAIT   = 3'd4;
    localparam logic [2:0] P_SHOW   = 3'd5;

    localparam logic [2:0] K_ENTER  = 3'b001;
    localparam logic [2:0] K_CANCEL = 3'b010;
    localparam logic [2:0] K_BOTH   = 3'b011;

    typedef struct {
        logic [2:0] keys;
        logic [3:0] sw;
        logic [2:0] phase;
        logic       valid;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key;
    logic [3:0] sw;
    logic [3:0] disp_r;
    logic       disp_ovf;
    logic [2:0] phase;

    int checks = 0;
    int errors = 0;

    calc_entry_seq_if bus ();

    calc_entry_seq #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .KEY      (key),
        .SW       (sw),
        .bus      (bus.master),
        .disp_r   (disp_r),
        .disp_ovf (disp_ovf),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Hold the masked keys down long enough to be accepted, then release and let it settle.
    task automatic applyStimulus(input logic [2:0] mask, input logic [3:0] value);
        @(negedge clk);
        sw  = value;
        key = ~mask;
        repeat (10) @(negedge clk);
        key = 3'b111;
        repeat (10) @(negedge clk);
    endtask

    task automatic handshake();
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
    endtask

    task automatic respond(input logic [3:0] r, input logic ovf);
        bus.rsp_valid = 1'b1;
        bus.rsp_r     = r;
        bus.rsp_ovf   = ovf;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
    endtask

    vec_t vecs [10];

    initial begin
        int         changes;
        logic [2:0] prev;

        vecs[0] = '{K_ENTER,  4'h3, P_GET_B,  1'b0, 4'h3, 4'h0, 3'd0};
        vecs[1] = '{K_ENTER,  4'h2, P_GET_OP, 1'b0, 4'h3, 4'h2, 3'd0};
        vecs[2] = '{K_CANCEL, 4'h6, P_GET_A,  1'b0, 4'h0, 4'h0, 3'd0};
        vecs[3] = '{K_ENTER,  4'hA, P_GET_B,  1'b0, 4'hA, 4'h0, 3'd0};
        vecs[4] = '{K_ENTER,  4'h7, P_GET_OP, 1'b0, 4'hA, 4'h7, 3'd0};
        vecs[5] = '{K_BOTH,   4'h5, P_GET_A,  1'b0, 4'h0, 4'h0, 3'd0};
        vecs[6] = '{K_ENTER,  4'h3, P_GET_B,  1'b0, 4'h3, 4'h0, 3'd0};
        vecs[7] = '{K_ENTER,  4'h2, P_GET_OP, 1'b0, 4'h3, 4'h2, 3'd0};
        vecs[8] = '{K_ENTER,  4'h9, P_ISSUE,  1'b1, 4'h3, 4'h2, 3'd1};
        vecs[9] = '{K_CANCEL, 4'hF, P_ISSUE,  1'b1, 4'h3, 4'h2, 3'd1};

        rst           = 1'b1;
        key           = 3'b111;
        sw            = 4'h0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_r     = 4'h0;
        bus.rsp_ovf   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_phase", {5'd0, phase}, {5'd0, P_GET_A});
        checkOutput("reset_valid", {7'd0, bus.cmd_valid}, 8'd0);
        checkOutput("reset_cmd", {bus.cmd_a, bus.cmd_b}, 8'h00);
        checkOutput("reset_op", {5'd0, bus.cmd_op}, 8'd0);
        checkOutput("reset_disp", {3'd0, disp_ovf, disp_r}, 8'h00);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("idle_no_press", {5'd0, phase}, {5'd0, P_GET_A});

        $display("[TB] bounce on ENTER");
        sw      = 4'h9;
        changes = 0;
        prev    = phase;
        for (int i = 0; i < 12; i++) begin
            key[0] = ((i / 2) % 2) != 0;
            @(negedge clk);
            if (phase !== prev) changes++;
            prev = phase;
        end
        key[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (phase !== prev) changes++;
            prev = phase;
        end
        key[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (phase !== prev) changes++;
            prev = phase;
        end
        checkOutput("bounce_changes", changes[7:0], 8'd1);
        checkOutput("bounce_phase", {5'd0, phase}, {5'd0, P_GET_B});
        checkOutput("bounce_a", {4'd0, bus.cmd_a}, 8'h09);

        applyStimulus(K_CANCEL, 4'h0);
        checkOutput("cancel_b_phase", {5'd0, phase}, {5'd0, P_GET_A});
        checkOutput("cancel_b_a", {4'd0, bus.cmd_a}, 8'h00);

        $display("[TB] entry table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].keys, vecs[i].sw);
            checkOutput($sformatf("vec%0d_phase", i), {5'd0, phase}, {5'd0, vecs[i].phase});
            checkOutput($sformatf("vec%0d_valid", i), {7'd0, bus.cmd_valid}, {7'd0, vecs[i].valid});
            checkOutput($sformatf("vec%0d_ab", i), {bus.cmd_a, bus.cmd_b}, {vecs[i].a, vecs[i].b});
            checkOutput($sformatf("vec%0d_op", i), {5'd0, bus.cmd_op}, {5'd0, vecs[i].op});
        end

        $display("[TB] stalled handshake");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d_valid", i), {7'd0, bus.cmd_valid}, 8'd1);
            checkOutput($sformatf("stall%0d_cmd", i), {bus.cmd_a, bus.cmd_b, 1'b0, bus.cmd_op} >> 4, 8'h32);
            checkOutput($sformatf("stall%0d_op", i), {5'd0, bus.cmd_op}, 8'd1);
        end
        handshake();
        checkOutput("hs_valid_drop", {7'd0, bus.cmd_valid}, 8'd0);
        checkOutput("hs_phase", {5'd0, phase}, {5'd0, P_WAIT});
        respond(4'h5, 1'b0);
        checkOutput("rsp1_disp", {3'd0, disp_ovf, disp_r}, 8'h05);
        checkOutput("rsp1_phase", {5'd0, phase}, {5'd0, P_SHOW});
        respond(4'h7, 1'b1);
        checkOutput("stray_rsp_ignored", {3'd0, disp_ovf, disp_r}, 8'h05);
        applyStimulus(K_ENTER, 4'h0);
        checkOutput("show_enter_phase", {5'd0, phase}, {5'd0, P_GET_A});
        checkOutput("show_enter_hold", {bus.cmd_a, disp_r}, 8'h35);

        $display("[TB] cancel during wait");
        applyStimulus(K_ENTER, 4'h1);
        applyStimulus(K_ENTER, 4'h1);
        applyStimulus(K_ENTER, 4'h0);
        checkOutput("t2_issue", {5'd0, phase}, {5'd0, P_ISSUE});
        handshake();
        key = 3'b101;
        repeat (9) @(negedge clk);
        checkOutput("wait_cancel_ignored", {5'd0, phase}, {5'd0, P_WAIT});
        respond(4'h8, 1'b1);
        checkOutput("rsp2_disp", {3'd0, disp_ovf, disp_r}, 8'h18);
        checkOutput("rsp2_phase", {5'd0, phase}, {5'd0, P_SHOW});
        key = 3'b111;
        repeat (10) @(negedge clk);
        checkOutput("rsp2_held", {5'd0, phase}, {5'd0, P_SHOW});
        applyStimulus(K_CANCEL, 4'h0);
        checkOutput("show_cancel_phase", {5'd0, phase}, {5'd0, P_GET_A});
        checkOutput("show_cancel_disp", {3'd0, disp_ovf, disp_r}, 8'h00);
        checkOutput("show_cancel_cmd", {bus.cmd_a, bus.cmd_b}, 8'h00);

        $display("[TB] no response");
        applyStimulus(K_ENTER, 4'h2);
        applyStimulus(K_ENTER, 4'h2);
        applyStimulus(K_ENTER, 4'h0);
        handshake();
        checkOutput("t3_wait", {5'd0, phase}, {5'd0, P_WAIT});
`ifdef CALC_TIMEOUT_EN
        repeat (15) @(negedge clk);
        checkOutput("tmo_not_yet", {5'd0, phase}, {5'd0, P_WAIT});
        @(negedge clk);
        checkOutput("tmo_phase", {5'd0, phase}, {5'd0, P_SHOW});
        checkOutput("tmo_disp", {3'd0, disp_ovf, disp_r}, 8'h10);
`else
        repeat (100) @(negedge clk);
        checkOutput("no_tmo_wait", {5'd0, phase}, {5'd0, P_WAIT});
        respond(4'h3, 1'b0);
        checkOutput("late_rsp_disp", {3'd0, disp_ovf, disp_r}, 8'h03);
        checkOutput("late_rsp_phase", {5'd0, phase}, {5'd0, P_SHOW});
`endif

        $display("[TB] reset mid-handshake");
        applyStimulus(K_ENTER, 4'h0);
        applyStimulus(K_ENTER, 4'h4);
        applyStimulus(K_ENTER, 4'h5);
        applyStimulus(K_ENTER, 4'h2);
        checkOutput("t4_valid", {7'd0, bus.cmd_valid}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_valid", {7'd0, bus.cmd_valid}, 8'd0);
        checkOutput("midrst_phase", {5'd0, phase}, {5'd0, P_GET_A});
        checkOutput("midrst_cmd", {bus.cmd_a, bus.cmd_b}, 8'h00);
        checkOutput("midrst_disp", {3'd0, disp_ovf, disp_r}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
